// File: rtl/ups_rst_pkg.sv
// Shared types and helpers for the UPS reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ups_rst_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT,
    DELAY,
    RUN,
    FAULT
  } rst_seq_state_t;

  // Width of the one shared down-stream counter. It must hold the largest
  // terminal count (max - 1). The result is floored at 1 bit so that a
  // degenerate all-ones parameter set still gives a legal vector.
  function automatic int cnt_width(input int hold_cyc, input int step_cyc,
                                   input int timeout_cyc);
    int m;
    m = hold_cyc;
    if (step_cyc > m) m = step_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ups_rst_seq.sv
// Sequenced release of N reset domains after POR / soft reset.
// Latency: stage i releases HOLD_CYC + (i+1)*(STEP_CYC+1) edges after reset drops.
// Backpressure: none; each stage waits on its own ready, and a timeout gives a sticky fault.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (from inverted por_n)
//   sw_rst_req   single-cycle soft restart request
//   stage_ready  per-stage ready, already synchronous to clk
//   stage_rst    per-stage active-high reset, registered
//   seq_done     all stages released, registered
//   seq_fault    sticky timeout fault, registered
//   fault_stage  index of the stage that timed out, registered
module ups_rst_seq
  import ups_rst_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYC    = 16,
  parameter int STEP_CYC    = 8,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rst_req,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                seq_done,
  output logic                seq_fault,
  output logic [IDX_W-1:0]    fault_stage
);

  localparam int CNT_W = cnt_width(HOLD_CYC, STEP_CYC, TIMEOUT_CYC);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);

  rst_seq_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst || sw_rst_req) begin
      // A soft request is a full restart: it also clears the sticky fault.
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      stage_rst   <= '1;
      seq_done    <= 1'b0;
      seq_fault   <= 1'b0;
      fault_stage <= '0;
    end else begin
      case (state)
        HOLD: begin
          stage_rst <= '1;
          seq_done  <= 1'b0;
          if (cnt == HOLD_LAST) begin
            state <= WAIT;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT: begin
          if (stage_ready[idx]) begin
            state <= DELAY;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            // Re-assert everything already released so downstream never
            // runs with a partially sequenced supply set.
            state       <= FAULT;
            stage_rst   <= '1;
            seq_fault   <= 1'b1;
            fault_stage <= idx;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DELAY: begin
          if (!stage_ready[idx]) begin
            // Ready bounced during settle: start over, including the timeout.
            state <= WAIT;
            cnt   <= '0;
          end else if (cnt == STEP_LAST) begin
            stage_rst[idx] <= 1'b0;
            if (idx == IDX_LAST) begin
              state    <= RUN;
              seq_done <= 1'b1;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= WAIT;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          // Any lost ready means a supply/clock went away: resequence from scratch.
          if (!(&stage_ready)) begin
            state     <= HOLD;
            cnt       <= '0;
            idx       <= '0;
            stage_rst <= '1;
            seq_done  <= 1'b0;
          end
        end

        FAULT: begin
          stage_rst <= '1;
          seq_done  <= 1'b0;
        end

        default: begin
          state     <= HOLD;
          cnt       <= '0;
          idx       <= '0;
          stage_rst <= '1;
          seq_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
